stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised N:1 stream multiplexer with a registered output and a valid/ready handshake.
//  It is the successor to the 2:1 combinational mux2.
//  It merges N producer channels (e.g. writeback/forwarding sources, memory request ports)
//  into one consumer, using either an externally driven select or round-robin arbitration.
//  The output register breaks the combinational path between producers and the consumer.
// PARAMETERS
//  WIDTH  32          data width per channel, >=1
//  N      4           number of input channels, >=2 (need not be a power of 2)
//  SELW   $clog2(N)   select/index width (derived; do not override)
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        synchronous, active-high reset
//  mode       in   1        0 = direct select, 1 = round-robin arbitration
//  sel        in   SELW     channel index used when mode=0
//  in_valid   in   N        per-channel valid; bit i belongs to channel i
//  in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_ready   out  N        per-channel ready (combinational)
//  out_valid  out  1        output register holds a beat
//  out_data   out  WIDTH    registered data
//  out_src    out  SELW     index of the channel that supplied out_data
//  out_ready  in   1        consumer accepts the beat on this clock edge
// BEHAVIOUR
//  Reset (sync, at posedge with reset=1):
//   - out_valid=0, out_data=0, out_src=0, rr_ptr=N-1.
//   - in_ready is 0 during reset; any beat offered in that cycle is not taken.
//  Load enable: load = !out_valid || out_ready.
//   - The output register advances only when load=1.
//   - Full throughput is 1 beat/clk.
//  Choice (combinational, evaluated every cycle):
//   - mode=0: chosen=sel; found = (sel<N) && in_valid[sel].
//   - mode=0, sel>=N: found=0 and no grant.
//   - mode=1: scan indices rr_ptr+1, rr_ptr+2, ... modulo N.
//     chosen = first index with in_valid set; found=0 if in_valid==0.
//  Grant:
//   - in_ready[i] = load && found && (i==chosen) && !reset.
//   - At most one in_ready bit is high (one-hot or zero).
//   - Transfer on channel i occurs when in_valid[i] && in_ready[i].
//  Registering (on posedge, when load=1):
//   - found=1: out_data <= in_data[chosen], out_src <= chosen, out_valid <= 1.
//   - found=0: out_valid <= 0; out_data and out_src hold their previous values.
//  Latency: 1 clk from input transfer to out_valid.
//  Backpressure: out_valid && !out_ready means out_data/out_src are held and all in_ready=0.
//  rr_ptr updates to chosen only on a transfer made while mode=1.
//   - Transfers with mode=0 leave rr_ptr unchanged.
//  Wrap-around: with rr_ptr=N-1 the scan starts at 0; the modulo also holds for non-power-of-2 N.
//  Simultaneous consume + load: the old beat leaves and the new beat enters on the same edge.
//   - No bubble, no duplicate.
//  Mode or sel change while a beat is held: the held beat is unaffected.
//   - The new mode/sel applies at the next load.
//  Reset mid-stream: a held beat is dropped, with no partial state; the next grant goes to the
//   lowest-index valid channel.
//  Producers must keep in_valid/in_data stable until accepted.
//   - The block does not check this; a dropped valid is a producer error.
// TESTING (WIDTH=32, N=4 unless stated)
//  1. Reset:
//     - hold reset 2 clk with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0.
//     - Next clk in mode=1 -> out_src=0.
//  2. Direct mode, streaming:
//     - mode=0, sel=2, ch2 streams 0xA0..0xA7, out_ready=1 -> out_data sequence 0xA0..0xA7,
//       1 beat/clk, 1 clk latency, out_src=2.
//     - in_ready[2] is the only ready bit.
//  3. Round-robin fairness:
//     - mode=1, in_valid=4'b1111 for 8 beats, out_ready=1 -> out_src 0,1,2,3,0,1,2,3.
//     - in_valid=4'b1010 -> out_src alternates 1,3.
//  4. Backpressure:
//     - out_ready=0 for 3 clk while out_valid=1, data 0x55 -> out_data stays 0x55, in_ready=0.
//     - Raise out_ready -> next beat follows with no loss or duplication (scoreboard check).
//  5. Edge cases:
//     - N=3, mode=0, sel=3 -> no grant, out_valid falls to 0.
//     - N=3, mode=1, rr_ptr=2 -> scan wraps to 0.
//     - Mode toggle while stalled: the held beat is unchanged.
//  6. Random soak:
//     - 10k clk of random valid/ready/mode/sel plus a mid-stream reset.
//     - Scoreboard: every accepted input appears exactly once, in order per channel.
//     - in_ready is one-hot or zero in every cycle.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream multiplexer with a registered output.
// Channel choice is either a direct select (mode=0) or round-robin arbitration
// (mode=1) that starts scanning just after the last channel granted in
// round-robin mode. The output register isolates producers from the consumer
// and sustains one beat per clock when the consumer keeps out_ready high.

module stream_mux_rr #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_src_q,   out_src_d;
  logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

  logic [WIDTH-1:0] in_word [N];
  logic             load;
  logic             found;
  logic [SELW-1:0]  chosen;
  int               scan_pos;
  logic [SELW-1:0]  scan_idx;

  // Unpack the flat data bus into one word per channel.
  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign in_word[g] = in_data[g*WIDTH +: WIDTH];
  end

  // The output register may take a new beat when empty or being drained.
  assign load = !out_valid_q || out_ready;

  // Choose the candidate channel: direct select, or first valid channel
  // after rr_ptr (modulo N, so non-power-of-2 N wraps correctly).
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold its old value.
    found    = 1'b0;
    chosen   = '0;
    scan_pos = 0;
    scan_idx = '0;
    if (!mode) begin
      if (32'(sel) < N) begin
        chosen = sel;
        found  = in_valid[sel];
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        scan_pos = int'(rr_ptr_q) + k;
        if (scan_pos >= N) scan_pos = scan_pos - N;
        scan_idx = SELW'(scan_pos);
        if (!found && in_valid[scan_idx]) begin
          found  = 1'b1;
          chosen = scan_idx;
        end
      end
    end
  end

  // Grant: at most one ready bit, only when the register can load.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load && found && (chosen == SELW'(i)) && !reset;
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = found;
      if (found) begin
        out_data_d = in_word[chosen];
        out_src_d  = chosen;
        if (mode) rr_ptr_d = chosen;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: the data register is reset too, because consumers may inspect
      // out_data right after reset and expect a defined zero.
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= SELW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed vectors on a 4-channel,
// 32-bit instance and a 3-channel, 8-bit instance, then a random soak on the
// 4-channel instance against a small reference model.

module tb_stream_mux_rr;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int W3 = 8;
  localparam int N3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic           reset, mode, out_ready;
  logic [1:0]     sel;
  logic [N-1:0]   in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;

  // 3-channel instance
  logic             r3_reset, r3_mode, r3_out_ready;
  logic [1:0]       r3_sel;
  logic [N3-1:0]    r3_in_valid, r3_in_ready;
  logic [N3*W3-1:0] r3_in_data;
  logic             r3_out_valid;
  logic [W3-1:0]    r3_out_data;
  logic [1:0]       r3_out_src;

  stream_mux_rr #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(W3), .N(N3)) dut3 (
    .clk(clk), .reset(r3_reset), .mode(r3_mode), .sel(r3_sel),
    .in_valid(r3_in_valid), .in_data(r3_in_data), .in_ready(r3_in_ready),
    .out_valid(r3_out_valid), .out_data(r3_out_data), .out_src(r3_out_src),
    .out_ready(r3_out_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [W-1:0] d);
    in_data[ch*W +: W] = d;
  endtask

  // Soak model state
  logic         pv [N];
  logic [W-1:0] pd [N];
  int unsigned  seq [N];
  int unsigned  last_seq [N];
  logic         have_last [N];
  logic         m_ov;
  logic [W-1:0] m_data;
  int           m_src, m_ptr, m_ch;
  logic         m_found, m_load;
  logic [N-1:0] exp_rdy;
  int           out_err, rdy_err, hot_err, order_err;
  int           accepted, consumed, dropped;

  initial begin
    // ---------------- 1. reset ----------------
    reset = 1'b1; mode = 1'b1; sel = 2'd0; out_ready = 1'b1; in_valid = 4'hF;
    for (int i = 0; i < N; i++) set_data(i, 32'hD0 + 32'(i));
    r3_reset = 1'b1; r3_mode = 1'b0; r3_sel = 2'd1; r3_out_ready = 1'b1;
    r3_in_valid = 3'b111;
    for (int i = 0; i < N3; i++) r3_in_data[i*W3 +: W3] = 8'h10 + 8'(i);
    #1;
    check("rst_ready_first", 64'(in_ready), 64'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_out_data",  64'(out_data),  64'h0);
      check("rst_in_ready",  64'(in_ready),  64'h0);
    end
    reset = 1'b0;
    #1;
    check("post_rst_grant", 64'(in_ready), 64'h1);
    tick();
    check("post_rst_src",   64'(out_src),   64'h0);
    check("post_rst_valid", 64'(out_valid), 64'h1);
    check("post_rst_data",  64'(out_data),  64'hD0);

    // ---------------- 2. direct streaming ----------------
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      set_data(2, 32'hA0 + 32'(k));
      #1;
      check("dir_ready", 64'(in_ready), 64'h4);
      tick();
      check("dir_data",  64'(out_data),  64'hA0 + 64'(k));
      check("dir_src",   64'(out_src),   64'h2);
      check("dir_valid", 64'(out_valid), 64'h1);
    end

    // ---------------- 3. round-robin fairness ----------------
    in_valid = 4'h0; reset = 1'b1;
    tick();
    reset = 1'b0; mode = 1'b1; in_valid = 4'hF;
    for (int i = 0; i < N; i++) set_data(i, 32'h100 + 32'(i));
    for (int b = 0; b < 8; b++) begin
      tick();
      check("rr_src",  64'(out_src),  64'(b % 4));
      check("rr_data", 64'(out_data), 64'h100 + 64'(b % 4));
    end
    in_valid = 4'b1010;
    for (int b = 0; b < 4; b++) begin
      tick();
      check("rr_alt_src", 64'(out_src), (b % 2 == 0) ? 64'd1 : 64'd3);
    end

    // ---------------- 4. backpressure ----------------
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; set_data(1, 32'h55);
    tick();
    check("bp_first", 64'(out_data), 64'h55);
    out_ready = 1'b0; set_data(1, 32'h66);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_ready_low", 64'(in_ready), 64'h0);
      tick();
      check("bp_hold_data",  64'(out_data),  64'h55);
      check("bp_hold_valid", 64'(out_valid), 64'h1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'h2);
    tick();
    check("bp_next_data",  64'(out_data),  64'h66);
    check("bp_next_valid", 64'(out_valid), 64'h1);
    in_valid = 4'h0;
    tick();
    check("bp_no_dup_valid", 64'(out_valid), 64'h0);
    check("bp_data_held",    64'(out_data),  64'h66);

    // mode toggle while stalled
    sel = 2'd3; in_valid = 4'b1000; set_data(3, 32'h77);
    tick();
    check("tog_load", 64'(out_data), 64'h77);
    out_ready = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; set_data(0, 32'h11);
    tick();
    tick();
    check("tog_hold_data", 64'(out_data), 64'h77);
    check("tog_hold_src",  64'(out_src),  64'h3);
    check("tog_ready",     64'(in_ready), 64'h0);
    out_ready = 1'b1;
    tick();
    check("tog_after_src",  64'(out_src),  64'h0);
    check("tog_after_data", 64'(out_data), 64'h11);

    // ---------------- 5. N=3 edge cases ----------------
    r3_reset = 1'b0;
    tick();
    check("n3_sel1_src",   64'(r3_out_src),   64'h1);
    check("n3_sel1_data",  64'(r3_out_data),  64'h11);
    r3_sel = 2'd3;
    #1;
    check("n3_sel3_ready", 64'(r3_in_ready), 64'h0);
    tick();
    check("n3_sel3_valid", 64'(r3_out_valid), 64'h0);
    check("n3_sel3_src",   64'(r3_out_src),   64'h1);
    r3_mode = 1'b1;
    #1;
    check("n3_wrap_ready", 64'(r3_in_ready), 64'h1);
    tick();
    check("n3_wrap_src",   64'(r3_out_src),  64'h0);
    check("n3_wrap_data",  64'(r3_out_data), 64'h10);
    r3_in_valid = 3'b100;
    tick();
    check("n3_ch2_src", 64'(r3_out_src), 64'h2);
    r3_in_valid = 3'b011;
    tick();
    check("n3_wrap2_src", 64'(r3_out_src), 64'h0);
    r3_in_valid = 3'b110;
    tick();
    check("n3_next_src", 64'(r3_out_src), 64'h1);

    // ---------------- 6. random soak ----------------
    out_err = 0; rdy_err = 0; hot_err = 0; order_err = 0;
    accepted = 0; consumed = 0; dropped = 0;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0; pd[i] = '0; seq[i] = 0; last_seq[i] = 0; have_last[i] = 1'b0;
    end
    in_valid = 4'h0; reset = 1'b1;
    tick();
    m_ov = 1'b0; m_data = '0; m_src = 0; m_ptr = N - 1;
    for (int c = 0; c < 10000; c++) begin
      reset     = (c >= 5000 && c < 5002);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int ch = 0; ch < N; ch++) begin
        if (!pv[ch] && $urandom_range(0, 1) == 1) begin
          pv[ch] = 1'b1;
          pd[ch] = {8'(ch), 24'(seq[ch])};
          seq[ch]++;
        end
        in_valid[ch] = pv[ch];
        set_data(ch, pd[ch]);
      end
      #1;
      if (out_valid !== m_ov) out_err++;
      if (m_ov && (out_data !== m_data || 32'(out_src) != 32'(m_src))) out_err++;

      m_load  = !m_ov || out_ready;
      m_found = 1'b0;
      m_ch    = 0;
      if (!mode) begin
        m_ch    = int'(sel);
        m_found = pv[m_ch];
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (!m_found && pv[(m_ptr + k) % N]) begin
            m_found = 1'b1;
            m_ch    = (m_ptr + k) % N;
          end
        end
      end
      exp_rdy = (!reset && m_load && m_found) ? 4'(1 << m_ch) : 4'h0;
      if (in_ready !== exp_rdy) rdy_err++;
      if ($countones(in_ready) > 1) hot_err++;

      if (!reset && m_ov && out_ready) begin
        if (int'(m_data[31:24]) != m_src) order_err++;
        if (have_last[m_src] && 32'(m_data[23:0]) <= last_seq[m_src]) order_err++;
        last_seq[m_src]  = 32'(m_data[23:0]);
        have_last[m_src] = 1'b1;
        consumed++;
      end

      if (reset) begin
        if (m_ov) dropped++;
        m_ov = 1'b0; m_data = '0; m_src = 0; m_ptr = N - 1;
      end else if (m_load) begin
        if (m_found) begin
          m_ov = 1'b1; m_data = pd[m_ch]; m_src = m_ch;
          pv[m_ch] = 1'b0;
          accepted++;
          if (mode) m_ptr = m_ch;
        end else begin
          m_ov = 1'b0;
        end
      end
      tick();
    end
    check("soak_out_mismatches",   64'(out_err),   64'h0);
    check("soak_ready_mismatches", 64'(rdy_err),   64'h0);
    check("soak_onehot_errors",    64'(hot_err),   64'h0);
    check("soak_order_errors",     64'(order_err), 64'h0);
    check("soak_exactly_once", 64'(accepted), 64'(consumed + dropped + (m_ov ? 1 : 0)));
    check("soak_traffic", 64'(consumed > 1000), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
